// File: rtl/i2c_slave_receiver.sv
// Write-only I2C target: oversampled SCL/SDA, 7-bit address match, sub-address + data
// register writes. Define I2C_SLAVE_AUTOINC_EN to accept burst data with auto-incremented address.
`timescale 1ns/1ps

module i2c_slave_receiver #(
    parameter logic [6:0] SLAVE_ADDR = 7'h1A
) (
    input  logic       CLOCK,
    input  logic       RESET,
    input  logic       I2C_SCLK,
    inout  wire        I2C_SDAT,
    output logic       WR_EN,
    output logic [7:0] WR_ADDR,
    output logic [7:0] WR_DATA,
    output logic       BUSY
);

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_ADDR     = 3'd1;
    localparam logic [2:0] ST_ADDR_ACK = 3'd2;
    localparam logic [2:0] ST_SUB      = 3'd3;
    localparam logic [2:0] ST_SUB_ACK  = 3'd4;
    localparam logic [2:0] ST_DATA     = 3'd5;
    localparam logic [2:0] ST_DATA_ACK = 3'd6;
    localparam logic [2:0] ST_IGNORE   = 3'd7;

    logic       scl_meta, scl_sync, scl_prev;
    logic       sda_meta, sda_sync, sda_prev;
    logic       scl_rise, scl_fall, sda_rise, sda_fall;
    logic       start_cond, stop_cond;
    logic [2:0] state;
    logic [3:0] bit_cnt;
    logic [7:0] shift_reg;
    logic       sda_low;
`ifdef I2C_SLAVE_AUTOINC_EN
    logic       first_data;
`endif

    // Synchronizers reset to the idle-bus level so reset release creates no false edges.
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            scl_meta <= 1'b1;
            scl_sync <= 1'b1;
            scl_prev <= 1'b1;
            sda_meta <= 1'b1;
            sda_sync <= 1'b1;
            sda_prev <= 1'b1;
        end else begin
            scl_meta <= I2C_SCLK;
            scl_sync <= scl_meta;
            scl_prev <= scl_sync;
            sda_meta <= I2C_SDAT;
            sda_sync <= sda_meta;
            sda_prev <= sda_sync;
        end
    end

    assign scl_rise   = scl_sync & ~scl_prev;
    assign scl_fall   = ~scl_sync & scl_prev;
    assign sda_rise   = sda_sync & ~sda_prev;
    assign sda_fall   = ~sda_sync & sda_prev;
    // A rising SCL counts as high, so a coincident SDA edge is a bus condition, not data.
    assign start_cond = sda_fall & scl_sync;
    assign stop_cond  = sda_rise & scl_sync;

    assign I2C_SDAT = sda_low ? 1'b0 : 1'bz;

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            state     <= ST_IDLE;
            bit_cnt   <= 4'd0;
            shift_reg <= 8'h00;
            sda_low   <= 1'b0;
            WR_EN     <= 1'b0;
            WR_ADDR   <= 8'h00;
            WR_DATA   <= 8'h00;
            BUSY      <= 1'b0;
`ifdef I2C_SLAVE_AUTOINC_EN
            first_data <= 1'b0;
`endif
        end else begin
            WR_EN <= 1'b0;
            if (start_cond) begin
                state   <= ST_ADDR;
                bit_cnt <= 4'd0;
                sda_low <= 1'b0;
                BUSY    <= 1'b0;
            end else if (stop_cond) begin
                state   <= ST_IDLE;
                bit_cnt <= 4'd0;
                sda_low <= 1'b0;
                BUSY    <= 1'b0;
            end else begin
                case (state)
                    ST_ADDR, ST_SUB, ST_DATA: begin
                        if (scl_rise && (bit_cnt < 4'd8)) begin
                            shift_reg <= {shift_reg[6:0], sda_sync};
                            bit_cnt   <= bit_cnt + 4'd1;
                        end else if (scl_fall && (bit_cnt == 4'd8)) begin
                            // Falling edge ending bit 7: decide the byte and open the ACK slot.
                            if (state == ST_ADDR) begin
                                if ((shift_reg[7:1] == SLAVE_ADDR) && !shift_reg[0]) begin
                                    state   <= ST_ADDR_ACK;
                                    sda_low <= 1'b1;
                                    BUSY    <= 1'b1;
                                end else begin
                                    state <= ST_IGNORE;
                                end
                            end else if (state == ST_SUB) begin
                                WR_ADDR <= shift_reg;
                                state   <= ST_SUB_ACK;
                                sda_low <= 1'b1;
`ifdef I2C_SLAVE_AUTOINC_EN
                                first_data <= 1'b1;
`endif
                            end else begin
                                WR_DATA <= shift_reg;
                                WR_EN   <= 1'b1;
                                state   <= ST_DATA_ACK;
                                sda_low <= 1'b1;
`ifdef I2C_SLAVE_AUTOINC_EN
                                if (!first_data) begin
                                    WR_ADDR <= WR_ADDR + 8'd1;
                                end
                                first_data <= 1'b0;
`endif
                            end
                        end
                    end
                    ST_ADDR_ACK, ST_SUB_ACK, ST_DATA_ACK: begin
                        if (scl_fall) begin
                            sda_low <= 1'b0;
                            bit_cnt <= 4'd0;
                            if (state == ST_ADDR_ACK) begin
                                state <= ST_SUB;
                            end else if (state == ST_SUB_ACK) begin
                                state <= ST_DATA;
                            end else begin
`ifdef I2C_SLAVE_AUTOINC_EN
                                state <= ST_DATA;
`else
                                state <= ST_IGNORE;
`endif
                            end
                        end
                    end
                    default: begin
                        sda_low <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_slave_receiver.sv
// Bench for i2c_slave_receiver: bit-banged master at CLOCK/32, transaction-level model
// of ACKs and write strobes, monitor comparing every WR_EN pulse against the model.
`timescale 1ns/1ps

module tb_i2c_slave_receiver;

    localparam int Q = 8;

    typedef struct packed {
        logic [7:0] addr;
        logic [7:0] data;
    } strobe_t;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       scl_pin = 1'b1;
    logic       master_sda_low = 1'b0;
    wire        sda_line;
    logic       wr_en;
    logic [7:0] wr_addr;
    logic [7:0] wr_data;
    logic       busy;

    int         compared = 0;
    int         mismatched = 0;
    strobe_t    exp_q[$];
    logic [7:0] tx_bytes[$];
    int         strobe_count = 0;
    logic [7:0] last_addr = 8'h00;
    logic [7:0] last_data = 8'h00;
    bit         checking = 1'b0;
    logic       prev_scl = 1'b1;
    logic       prev_sda = 1'b1;
    logic       prev_master = 1'b0;

    assign sda_line = master_sda_low ? 1'b0 : 1'bz;
    pullup (sda_line);

    i2c_slave_receiver #(.SLAVE_ADDR(7'h1A)) dut (
        .CLOCK    (clock),
        .RESET    (reset),
        .I2C_SCLK (scl_pin),
        .I2C_SDAT (sda_line),
        .WR_EN    (wr_en),
        .WR_ADDR  (wr_addr),
        .WR_DATA  (wr_data),
        .BUSY     (busy)
    );

    always #5 clock = ~clock;

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Every strobe must match the next expected write; SDA must never move during SCL high unless the master moved it.
    always @(negedge clock) begin
        strobe_t e;
        if (checking) begin
            if (wr_en) begin
                strobe_count++;
                last_addr = wr_addr;
                last_data = wr_data;
                if (exp_q.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("[TB] FAIL unexpected_strobe: got addr %0h data %0h, expected no strobe", wr_addr, wr_data);
                end else begin
                    e = exp_q.pop_front();
                    check_output("strobe_wr_addr", {24'd0, wr_addr}, {24'd0, e.addr});
                    check_output("strobe_wr_data", {24'd0, wr_data}, {24'd0, e.data});
                end
            end
            if (scl_pin && prev_scl && (master_sda_low == prev_master)) begin
                check_output("sda_stable_scl_high", {31'd0, sda_line}, {31'd0, prev_sda});
            end
        end
        prev_scl    = scl_pin;
        prev_sda    = sda_line;
        prev_master = master_sda_low;
    end

    task automatic wait_q();
        repeat (Q) @(negedge clock);
    endtask

    task automatic bus_start();
        master_sda_low = 1'b0;
        wait_q();
        scl_pin = 1'b1;
        wait_q();
        master_sda_low = 1'b1;
        wait_q();
        scl_pin = 1'b0;
        wait_q();
    endtask

    task automatic bus_stop();
        master_sda_low = 1'b1;
        wait_q();
        scl_pin = 1'b1;
        wait_q();
        master_sda_low = 1'b0;
        wait_q();
        wait_q();
    endtask

    task automatic send_bit(input logic b);
        master_sda_low = ~b;
        wait_q();
        scl_pin = 1'b1;
        wait_q();
        wait_q();
        scl_pin = 1'b0;
        wait_q();
    endtask

    task automatic send_byte(input logic [7:0] b, output bit acked);
        for (int i = 7; i >= 0; i--) begin
            send_bit(b[i]);
        end
        master_sda_low = 1'b0;
        wait_q();
        scl_pin = 1'b1;
        wait_q();
        acked = (sda_line === 1'b0);
        wait_q();
        scl_pin = 0;
        wait_q();
    endtask

    // Transaction model: which bytes the target acknowledges and which register writes result.
    function automatic bit model_ack(input int k, input bit matched);
        if (!matched) return 1'b0;
        if (k <= 2) return 1'b1;
`ifdef I2C_SLAVE_AUTOINC_EN
        return 1'b1;
`else
        return 1'b0;
`endif
    endfunction

    task automatic apply_stimulus(input bit do_stop);
        bit      matched;
        bit      acked;
        strobe_t s;
        matched = (tx_bytes[0][7:1] == 7'h1A) && !tx_bytes[0][0];
        for (int k = 2; k < tx_bytes.size(); k++) begin
            if (model_ack(k, matched)) begin
                s.addr = tx_bytes[1] + 8'(k - 2);
                s.data = tx_bytes[k];
                exp_q.push_back(s);
            end
        end
        bus_start();
        for (int k = 0; k < tx_bytes.size(); k++) begin
            send_byte(tx_bytes[k], acked);
            check_output($sformatf("ack_byte%0d", k), {31'd0, acked}, {31'd0, model_ack(k, matched)});
            if (k == 0) begin
                check_output("busy_after_addr", {31'd0, busy}, {31'd0, matched});
            end
        end
        if (do_stop) begin
            bus_stop();
            check_output("busy_after_stop", {31'd0, busy}, 32'd0);
            check_output("strobes_pending", exp_q.size(), 32'd0);
        end
    endtask

    initial begin
        int base;
        repeat (4) @(negedge clock);
        check_output("reset_wr_en", {31'd0, wr_en}, 32'd0);
        check_output("reset_wr_addr", {24'd0, wr_addr}, 32'h00);
        check_output("reset_wr_data", {24'd0, wr_data}, 32'h00);
        check_output("reset_busy", {31'd0, busy}, 32'd0);
        check_output("reset_sda", {31'd0, sda_line}, 32'd1);
        reset = 1'b0;
        repeat (4) @(negedge clock);
        checking = 1'b1;

        $display("[TB] basic write 34/08/12");
        base = strobe_count;
        tx_bytes = {8'h34, 8'h08, 8'h12};
        apply_stimulus(1'b1);
        check_output("basic_strobe_count", strobe_count - base, 32'd1);
        check_output("basic_last_addr", {24'd0, last_addr}, 32'h08);
        check_output("basic_last_data", {24'd0, last_data}, 32'h12);
        check_output("hold_wr_addr", {24'd0, wr_addr}, 32'h08);
        check_output("hold_wr_data", {24'd0, wr_data}, 32'h12);

        $display("[TB] foreign address 36");
        base = strobe_count;
        tx_bytes = {8'h36, 8'h11, 8'h22};
        apply_stimulus(1'b1);
        check_output("foreign_strobe_count", strobe_count - base, 32'd0);

        $display("[TB] read address 35");
        base = strobe_count;
        tx_bytes = {8'h35, 8'h44};
        apply_stimulus(1'b1);
        check_output("read_strobe_count", strobe_count - base, 32'd0);

        $display("[TB] abort mid data byte, then full write");
        base = strobe_count;
        tx_bytes = {8'h34, 8'h10};
        apply_stimulus(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        bus_stop();
        check_output("abort_strobe_count", strobe_count - base, 32'd0);
        check_output("abort_busy", {31'd0, busy}, 32'd0);
        tx_bytes = {8'h34, 8'h0A, 8'h55};
        apply_stimulus(1'b1);
        check_output("after_abort_count", strobe_count - base, 32'd1);
        check_output("after_abort_addr", {24'd0, last_addr}, 32'h0A);
        check_output("after_abort_data", {24'd0, last_data}, 32'h55);

        $display("[TB] reset while holding sub-address ACK");
        tx_bytes = {8'h34};
        apply_stimulus(1'b0);
        for (int i = 7; i >= 0; i--) begin
            send_bit(i == 3);
        end
        master_sda_low = 1'b0;
        @(negedge clock);
        check_output("sub_ack_held_low", {31'd0, sda_line}, 32'd0);
        reset = 1'b1;
        @(posedge clock);
        #1;
        check_output("reset_releases_sda", {31'd0, sda_line}, 32'd1);
        check_output("reset_mid_wr_en", {31'd0, wr_en}, 32'd0);
        check_output("reset_mid_wr_addr", {24'd0, wr_addr}, 32'h00);
        check_output("reset_mid_wr_data", {24'd0, wr_data}, 32'h00);
        check_output("reset_mid_busy", {31'd0, busy}, 32'd0);
        @(negedge clock);
        reset = 1'b0;
        repeat (4) @(negedge clock);
        base = strobe_count;
        tx_bytes = {8'h34, 8'h20, 8'h5A};
        apply_stimulus(1'b1);
        check_output("post_reset_count", strobe_count - base, 32'd1);
        check_output("post_reset_addr", {24'd0, last_addr}, 32'h20);
        check_output("post_reset_data", {24'd0, last_data}, 32'h5A);

        $display("[TB] burst write 34/FF/A1/A2");
        base = strobe_count;
        tx_bytes = {8'h34, 8'hFF, 8'hA1, 8'hA2};
        apply_stimulus(1'b1);
`ifdef I2C_SLAVE_AUTOINC_EN
        check_output("burst_count", strobe_count - base, 32'd2);
        check_output("burst_last_addr", {24'd0, last_addr}, 32'h00);
        check_output("burst_last_data", {24'd0, last_data}, 32'hA2);
`else
        check_output("burst_count", strobe_count - base, 32'd1);
        check_output("burst_last_addr", {24'd0, last_addr}, 32'hFF);
        check_output("burst_last_data", {24'd0, last_data}, 32'hA1);
`endif

        repeat (8) @(negedge clock);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
